// File: rtl/ser_pkg.sv
// Shared constants for the ser_to_par serial-to-parallel stage.
package ser_pkg;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/dff_nr.sv
// One-bit rising-edge D flip-flop with asynchronous active-low clear.
module dff_nr (
  output logic Q,
  input  logic D,
  input  logic C,
  input  logic nR
);

  always_ff @(posedge C or negedge nR) begin
    if (!nR) Q <= 1'b0;
    else     Q <= D;
  end

endmodule

// File: rtl/ser_to_par.sv
// Serial-to-parallel stage: assembles WIDTH serial bits into Q with valid/ready.
// Build option SER_MSB_FIRST_EN: bits enter at Q[0] and shift toward the MSB.
module ser_to_par
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             C,
  input  logic             nR,
  input  logic             D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ser_to_par: WIDTH outside legal range");
  end

  logic             state;
  logic             state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] q_next;

  assign accept   = in_valid && (state == ST_FILL);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State bit lives in the same storage primitive as the data.
  dff_nr u_state (
    .Q  (state),
    .D  (state_next),
    .C  (C),
    .nR (nR)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if (accept && last_bit) state_next = ST_HOLD;
      ST_HOLD: if (out_ready)          state_next = ST_FILL;
      default:                         state_next = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_FILL);
    out_valid = (state == ST_HOLD);
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last_bit ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef SER_MSB_FIRST_EN
  assign q_shift = {Q[WIDTH-2:0], D};
`else
  assign q_shift = {D, Q[WIDTH-1:1]};
`endif

  assign q_next = accept ? q_shift : Q;

  // Q is driven directly from these flops; it is never cleared between words.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sr
    dff_nr u_bit (
      .Q  (Q[i]),
      .D  (q_next[i]),
      .C  (C),
      .nR (nR)
    );
  end

endmodule

// File: tb/tb_ser_to_par.sv
// Self-checking bench for ser_to_par (WIDTH=4), randomized against a history-based model.
module tb_ser_to_par;

  localparam int unsigned W = 4;

  logic         C;
  logic         nR;
  logic         D;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Q;
  logic         out_valid;
  logic         out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every accepted bit since reset, plus whether a word is held.
  bit hist[$];
  int m_cnt;
  bit m_hold;

  ser_to_par #(.WIDTH(W)) dut (
    .C         (C),
    .nR        (nR),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < int'(W); i++) hist.push_back(1'b0);
    m_cnt  = 0;
    m_hold = 1'b0;
  endfunction

  // Word = last W accepted bits; newest bit sits at the entry end of the register.
  function automatic logic [W-1:0] model_q();
    logic [W-1:0] q;
    q = '0;
    for (int k = 0; k < int'(W); k++) begin
`ifdef SER_MSB_FIRST_EN
      q[k] = hist[hist.size() - 1 - k];
`else
      q[W - 1 - k] = hist[hist.size() - 1 - k];
`endif
    end
    return q;
  endfunction

  task automatic step(input bit v, input bit d, input bit r);
    in_valid  = v;
    D         = d;
    out_ready = r;
    @(posedge C);
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > W) void'(hist.pop_front());
      m_cnt++;
      if (m_cnt == int'(W)) begin
        m_cnt  = 0;
        m_hold = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] bits, input bit r);
    for (int i = 0; i < int'(W); i++) step(1'b1, bits[i], r);
  endtask

  task automatic test_reset();
    nR = 1'b0; in_valid = 1'b0; D = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    n_tests++;
    if (Q !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Q=%b in_ready=%b out_valid=%b, want 0000/1/0", Q, in_ready, out_valid);
    end
    @(negedge C);
    nR = 1'b1;
    @(posedge C); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_q;
`ifdef SER_MSB_FIRST_EN
    exp_q = 4'b1011;
`else
    exp_q = 4'b1101;
`endif
    send_word(4'b1101, 1'b1);  // stream 1,0,1,1 (bit i sent i-th)
    n_tests++;
    if (out_valid !== 1'b1 || Q !== exp_q || Q !== model_q()) begin
      n_fail++;
      $display("FAIL basic_word: Q=%b out_valid=%b, want %b/1", Q, out_valid, exp_q);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    send_word(4'b1101, 1'b0);
    held = model_q();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bit'(i[0]), 1'b0);
      n_tests++;
      if (Q !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: Q=%b in_ready=%b out_valid=%b, want %b/0/1",
                 i, Q, in_ready, out_valid, held);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== held) begin
      n_fail++;
      $display("FAIL backpressure_release: Q=%b in_ready=%b out_valid=%b, want %b/1/0",
               Q, in_ready, out_valid, held);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    #2 nR = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (Q !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: Q=%b in_ready=%b out_valid=%b, want 0000/1/0", Q, in_ready, out_valid);
    end
    #2 nR = 1'b1;
    send_word(4'b0110, 1'b1);
    n_tests++;
    if (Q !== 4'b0110 || out_valid !== 1'b1 || Q !== model_q()) begin
      n_fail++;
      $display("FAIL reset_mid_word: Q=%b out_valid=%b, want 0110/1", Q, out_valid);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gap();
    logic [W-1:0] exp_q;
`ifdef SER_MSB_FIRST_EN
    exp_q = 4'b1100;
`else
    exp_q = 4'b0011;
`endif
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_early_valid: out_valid=%b in_ready=%b after 3 accepts, want 0/1", out_valid, in_ready);
    end
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || Q !== exp_q) begin
      n_fail++;
      $display("FAIL gap_word: Q=%b out_valid=%b, want %b/1", Q, out_valid, exp_q);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bubbles = 0;
    for (int c = 0; c < 2 * (int'(W) + 1); c++) begin
      step(1'b1, 1'($urandom_range(1, 0)), 1'b1);
      if (out_valid === 1'b1) pulses++;
      if (in_ready === 1'b0) bubbles++;
      n_tests++;
      if (out_valid !== m_hold || in_ready !== !m_hold || Q !== model_q()) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: Q=%b ov=%b ir=%b, want %b/%b/%b",
                 c, Q, out_valid, in_ready, model_q(), m_hold, !m_hold);
      end
    end
    n_tests++;
    if (pulses != 2 || bubbles != 2) begin
      n_fail++;
      $display("FAIL back_to_back_count: pulses=%0d bubbles=%0d, want 2/2", pulses, bubbles);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0));
      n_tests++;
      if (out_valid !== m_hold || in_ready !== !m_hold || Q !== model_q()) begin
        n_fail++;
        $display("FAIL random[%0d]: Q=%b ov=%b ir=%b, want %b/%b/%b",
                 c, Q, out_valid, in_ready, model_q(), m_hold, !m_hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_gap();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_to_par.md
# ser_to_par

Serial-to-parallel register stage that sits directly downstream of the D-latch/flip-flop storage cells. It consumes a single-bit data stream, one bit per accepted clock edge, and assembles it into a WIDTH-bit word. The word is presented on Q with a valid/ready handshake, so a downstream register file or ALU input can take it when it is ready. Storage is built from edge-triggered D flip-flops with an asynchronous active-low clear, matching the existing storage primitives.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- C  input  1  clock; all state updates on its rising edge.
- nR  input  1  reset, asynchronous, active-low; clears all state immediately, independent of C.
- D  input  1  serial data bit.
- in_valid  input  1  D carries a bit this cycle.
- in_ready  output  1  stage can accept a bit this cycle.
- Q  output  WIDTH  assembled parallel word.
- out_valid  output  1  Q holds a complete word.
- out_ready  input  1  downstream takes Q this cycle.

## Operation
- Two states, encoded in one bit:
  - FILL (0): collecting bits.
  - HOLD (1): a word is held for the consumer.
- Bit accept:
  - Occurs when in_valid && in_ready at a rising edge of C.
  - Each accept shifts D into the shift register and increments a bit counter cnt (width clog2(WIDTH), range 0..WIDTH-1).
- FILL -> HOLD: an accept with cnt == WIDTH-1. cnt wraps to 0 on the same edge.
- HOLD -> FILL: out_valid && out_ready at an edge. Q keeps its value until the next accept overwrites it bit by bit.
- in_ready = (state == FILL). Bits presented in HOLD are ignored, and D is a don't-care there.
- out_valid = (state == HOLD).
- Q is the shift register itself. It is not cleared between words and is driven straight from flops, with no combinational path from D.
- Gaps in in_valid during FILL are legal. cnt and the partial word hold their values through a gap.
- If in_valid is present in the same cycle as a HOLD -> FILL transition, the bit is not accepted because in_ready is 0 in HOLD. This gives a fixed one-cycle bubble per word.
- Reset values (nR low): state = FILL, cnt = 0, Q = 0, out_valid = 0, in_ready = 1.
- Reset mid-word: the partial word is discarded. The first accept after release is bit 0 of a new word.

## Timing
- Latency: out_valid rises on the same rising edge of C that accepts the WIDTH-th bit. Q is complete at that edge.
- Throughput: one word per WIDTH+1 cycles at best (WIDTH accepts plus 1 hold cycle with out_ready high).
- Backpressure: while out_ready is low, Q and out_valid stay stable indefinitely and in_ready stays 0.
- nR assertion takes effect asynchronously.
- nR deassertion is synchronised by the surrounding design. The first possible accept is the first rising edge of C with nR high.

## Configuration
- SER_MSB_FIRST_EN
  - Defined: bits enter at Q[0] and shift toward the MSB (Q <= {Q[WIDTH-2:0], D}). The first accepted bit ends in Q[WIDTH-1].
  - Undefined (default): bits enter at Q[WIDTH-1] and shift toward the LSB (Q <= {D, Q[WIDTH-1:1]}). The first accepted bit ends in Q[0].
- The handshake, counter and reset behaviour are identical in both builds.

## Structure
- Shared package ser_pkg holds:
  - State constants ST_FILL = 1'b0 and ST_HOLD = 1'b1.
  - Constants WIDTH_MIN = 2 and WIDTH_MAX = 32, used for an elaboration-time range check.
- Sub-module dff_nr: one-bit rising-edge D flip-flop with asynchronous active-low clear (ports Q, D, C, nR).
  - Instantiated WIDTH times for the shift register, plus once for the state bit.
  - cnt may be built from dff_nr instances or written behaviourally.

## Test plan
- WIDTH=4, default build; send 1,0,1,1 on consecutive edges with out_ready=1 -> out_valid high after edge 4, Q=4'b1101; out_valid low after edge 5.
- Same stream with SER_MSB_FIRST_EN defined -> Q=4'b1011.
- Complete a word with out_ready=0 for 3 cycles while in_valid=1, D toggling -> Q stays 4'b1101, in_ready=0, no bits absorbed; out_ready=1 -> FILL next edge.
- Accept 2 bits, pull nR low between edges -> Q=0, in_ready=1, out_valid=0 immediately without a clock; release, send 0,1,1,0 -> Q=4'b0110.
- Send 1,1,0,0 with in_valid low for 2 cycles between bit 2 and bit 3 -> Q=4'b0011, out_valid exactly after the 4th accept.
- Two back-to-back words with out_ready tied high -> out_valid pulses once per word, one-cycle bubble on in_ready each time.
